icache: RTL and testbench
=========================

# icache

Direct-mapped, single-word-line instruction cache between the instruction fetch stage and the memory controller. It accepts one fetch address at a time from IF and returns the 32-bit instruction word with a one-cycle valid pulse. On a miss it performs a single-word refill through a request/done handshake with the memory controller. A branch-mispredict flush from the ROB cancels delivery of any in-flight fetch.

## Interface
Parameters:
- INDEX_BITS, 6, log2 of line count; 64 lines of one 32-bit word each.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global enable; when low, every register holds its value, including outputs.
- pc_cache  in  32  fetch address from IF.
- pc_flag  in  1  IF fetch request; sampled only in IDLE.
- ins_ori  out  32  instruction word to IF.
- ins_ori_flag  out  1  one-cycle pulse: ins_ori valid.
- jp_wrong  in  1  ROB mispredict flush.
- mc_req  out  1  refill request to memory controller; level, held until done.
- mc_addr  out  32  refill word address, {pc[31:2],2'b00}.
- mc_data  in  32  refill word, valid when mc_done=1.
- mc_done  in  1  one-cycle refill completion.

## Operation
- Address split: index = pc[INDEX_BITS+1:2], tag = pc[31:INDEX_BITS+2], pc[1:0] ignored.
- Storage: valid[2^INDEX_BITS], tag array, data array. Only valid bits are reset.
- States: IDLE, FILL.
- IDLE, pc_flag=1, jp_wrong=0:
  - Hit (valid && tag match): register the data word into ins_ori and pulse ins_ori_flag. Stay in IDLE.
  - Miss: latch the request address, set mc_req=1, drive mc_addr, go to FILL. ins_ori_flag stays 0.
- IDLE with jp_wrong=1: the request is ignored. No lookup, no output, no refill.
- FILL:
  - pc_flag is ignored.
  - mc_req and mc_addr stay constant until mc_done.
  - jp_wrong=1 in any FILL cycle sets the internal `flushed` bit. The memory transaction is not aborted.
  - On mc_done: write data/tag and set valid for the latched index, drop mc_req, return to IDLE.
  - Output on mc_done: if flushed=0 and jp_wrong=0 that cycle, drive ins_ori=mc_data and pulse ins_ori_flag. Otherwise there is no output. Clear flushed.
- mc_done while IDLE is ignored.
- Refill overwrites any previous line at that index (direct-mapped replacement).
- rdy=0 freezes the FSM, arrays, mc_req/mc_addr, ins_ori and ins_ori_flag. mc_done arriving while rdy=0 is not sampled; the memory controller shares rdy and is frozen too.

## Timing
- Reset values: ins_ori=0, ins_ori_flag=0, mc_req=0, mc_addr=0, state=IDLE, flushed=0, all valid=0.
- Reset is effective immediately and asynchronously, including mid-FILL: mc_req drops at once and no pulse is produced.
- Hit latency: request at edge t, ins_ori_flag=1 during cycle t+1, for exactly one cycle.
- Miss:
  - Request at edge t: mc_req=1 from cycle t+1.
  - mc_done sampled at edge d: ins_ori_flag=1 and mc_req=0 during cycle d+1.
  - Total latency is (d−t)+1 cycles.
- Back-to-back hits: the next request may be accepted in the same cycle the previous pulse is shown, giving one instruction per cycle.
- The earliest new request after a miss is accepted in cycle d+1, when the FSM is back in IDLE.
- ins_ori_flag is never high for two consecutive cycles for the same request.
- ins_ori holds its last value when ins_ori_flag=0.

## Test plan
- Reset, then request pc=0x0000_0000 → miss: mc_req=1, mc_addr=0x0. Return mc_done with mc_data=0x0000_0093 three cycles later → one-cycle ins_ori_flag with ins_ori=0x0000_0093, mc_req=0.
- Re-request pc=0x0 → ins_ori_flag next cycle with 0x0000_0093 and no mc_req. Three consecutive hit requests → three consecutive pulses.
- Conflict test:
  - Fill pc=0x0000_0104 (index 1), then request pc=0x0000_0204 (same index, different tag) → miss and refill with 0xDEAD_BEEF.
  - Re-request 0x104 → miss again.
- Flush mid-refill: jp_wrong=1 for one cycle during FILL, mc_done later → no ins_ori_flag pulse, line still valid. A later request to the same pc hits.
- Simultaneous events:
  - pc_flag=1 with jp_wrong=1 in IDLE on a cached address → no pulse.
  - mc_done and jp_wrong in the same cycle → no pulse, line filled.
- Hold and reset:
  - rdy=0 for 4 cycles during FILL with mc_done asserted under rdy=0 → no state change. mc_done after rdy returns high → normal pulse.
  - rst pulse mid-FILL → mc_req=0 immediately, and all lines miss afterward.

Source files
------------

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache
//
// Direct-mapped instruction cache with one 32-bit word per line. It sits
// between the instruction-fetch stage (IF) and the memory controller (MC).
//
// IF issues one fetch at a time. A hit returns the word one cycle later with
// a single-cycle valid pulse. A miss runs a single-word refill through a
// level request and a one-cycle done. After the refill the word is forwarded
// to IF, unless a mispredict flush arrived during the refill.
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   rdy           in   global enable; low freezes every register
//   pc_cache      in   fetch address from IF
//   pc_flag       in   fetch request from IF, sampled only while idle
//   ins_ori       out  instruction word to IF, holds when no pulse
//   ins_ori_flag  out  one-cycle pulse, ins_ori valid
//   jp_wrong      in   ROB mispredict flush
//   mc_req        out  refill request, level, held until mc_done
//   mc_addr       out  refill word address, {pc[31:2], 2'b00}
//   mc_data       in   refill word, valid with mc_done
//   mc_done       in   one-cycle refill completion
// -----------------------------------------------------------------------------
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] pc_cache,
  input  logic        pc_flag,
  output logic [31:0] ins_ori,
  output logic        ins_ori_flag,
  input  logic        jp_wrong,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic [31:0] mc_data,
  input  logic        mc_done
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             r_state;
  logic               r_flushed;     // a flush was seen during the current refill
  logic               r_mc_req;
  logic [31:0]        r_mc_addr;     // latched miss address, also the fill target
  logic [31:0]        r_ins_ori;
  logic               r_ins_ori_flag;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [31:0]        r_data [LINES];

  // ---------------------------------------------------------------------------
  // Next-state values
  // ---------------------------------------------------------------------------
  state_t             w_state_nxt;
  logic               w_flushed_nxt;
  logic               w_mc_req_nxt;
  logic [31:0]        w_mc_addr_nxt;
  logic [31:0]        w_ins_ori_nxt;
  logic               w_ins_ori_flag_nxt;
  logic               w_fill_we;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_W-1:0]      w_tag;
  logic [INDEX_BITS-1:0] w_fill_index;
  logic [TAG_W-1:0]      w_fill_tag;
  logic                  w_hit;
  logic                  w_unused_pc_bits;

  assign w_index      = pc_cache[INDEX_BITS+1:2];
  assign w_tag        = pc_cache[31:INDEX_BITS+2];
  assign w_fill_index = r_mc_addr[INDEX_BITS+1:2];
  assign w_fill_tag   = r_mc_addr[31:INDEX_BITS+2];
  assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);

  // The byte offset is irrelevant for word fetches.
  assign w_unused_pc_bits = ^pc_cache[1:0];

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    w_state_nxt        = r_state;
    w_flushed_nxt      = r_flushed;
    w_mc_req_nxt       = r_mc_req;
    w_mc_addr_nxt      = r_mc_addr;
    w_ins_ori_nxt      = r_ins_ori;
    w_ins_ori_flag_nxt = 1'b0;
    w_fill_we          = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // A fetch that arrives together with a flush is already on the wrong
        // path, so it is dropped without a lookup or a refill.
        if (pc_flag && !jp_wrong) begin
          if (w_hit) begin
            w_ins_ori_nxt      = r_data[w_index];
            w_ins_ori_flag_nxt = 1'b1;
          end else begin
            w_mc_addr_nxt = {pc_cache[31:2], 2'b00};
            w_mc_req_nxt  = 1'b1;
            w_flushed_nxt = 1'b0;
            w_state_nxt   = S_FILL;
          end
        end
      end

      S_FILL: begin
        // The memory transaction always completes. A flush only suppresses
        // delivery of the word, while the line is still installed.
        if (jp_wrong) begin
          w_flushed_nxt = 1'b1;
        end
        if (mc_done) begin
          w_fill_we     = 1'b1;
          w_mc_req_nxt  = 1'b0;
          w_flushed_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
          if (!r_flushed && !jp_wrong) begin
            w_ins_ori_nxt      = mc_data;
            w_ins_ori_flag_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers and valid bits
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_flushed      <= 1'b0;
      r_mc_req       <= 1'b0;
      r_mc_addr      <= 32'h0;
      r_ins_ori      <= 32'h0;
      r_ins_ori_flag <= 1'b0;
      r_valid        <= '0;
    end else if (rdy) begin
      r_state        <= w_state_nxt;
      r_flushed      <= w_flushed_nxt;
      r_mc_req       <= w_mc_req_nxt;
      r_mc_addr      <= w_mc_addr_nxt;
      r_ins_ori      <= w_ins_ori_nxt;
      r_ins_ori_flag <= w_ins_ori_flag_nxt;
      if (w_fill_we) begin
        r_valid[w_fill_index] <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tag and data arrays
  // ---------------------------------------------------------------------------
  // NOTE: the arrays have no reset. The cleared valid bits already make any
  // stale tag or data invisible, and leaving the reset off lets the arrays map
  // onto plain RAM.
  always_ff @(posedge clk) begin
    if (rdy && w_fill_we) begin
      r_tag[w_fill_index]  <= w_fill_tag;
      r_data[w_fill_index] <= mc_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ins_ori      = r_ins_ori;
  assign ins_ori_flag = r_ins_ori_flag;
  assign mc_req       = r_mc_req;
  assign mc_addr      = r_mc_addr;

endmodule

// File: tb/tb_icache.sv
// -----------------------------------------------------------------------------
// tb_icache
//
// Directed bench for icache. A table of per-cycle vectors holds the inputs
// driven for one clock cycle and the outputs expected just after that edge.
// Hand-written sequences cover the reset state and an asynchronous reset
// taken mid-refill.
// -----------------------------------------------------------------------------
module tb_icache;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [31:0] pc_cache;
  logic        pc_flag;
  logic [31:0] ins_ori;
  logic        ins_ori_flag;
  logic        jp_wrong;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic [31:0] mc_data;
  logic        mc_done;

  int n_checks = 0;
  int n_errors = 0;

  icache #(.INDEX_BITS(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .pc_cache     (pc_cache),
    .pc_flag      (pc_flag),
    .ins_ori      (ins_ori),
    .ins_ori_flag (ins_ori_flag),
    .jp_wrong     (jp_wrong),
    .mc_req       (mc_req),
    .mc_addr      (mc_addr),
    .mc_data      (mc_data),
    .mc_done      (mc_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          rdy;
    bit          pc_flag;
    logic [31:0] pc;
    bit          jp_wrong;
    bit          mc_done;
    logic [31:0] mc_data;
    bit          e_flag;
    logic [31:0] e_ins;
    bit          e_req;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input bit r, input bit pf, input logic [31:0] pc,
                     input bit jw, input bit dn, input logic [31:0] d,
                     input bit ef, input logic [31:0] ei, input bit er,
                     input logic [31:0] ea);
    vec_t v;
    v.name = n;  v.rdy = r;  v.pc_flag = pf;  v.pc = pc;  v.jp_wrong = jw;
    v.mc_done = dn;  v.mc_data = d;  v.e_flag = ef;  v.e_ins = ei;
    v.e_req = er;  v.e_addr = ea;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string name, input bit ef, input logic [31:0] ei,
                               input bit er, input logic [31:0] ea);
    check({name, ".flag"}, {31'b0, ins_ori_flag}, {31'b0, ef});
    check({name, ".ins"},  ins_ori,               ei);
    check({name, ".req"},  {31'b0, mc_req},       {31'b0, er});
    check({name, ".addr"}, mc_addr,               ea);
  endtask

  // Outputs are sampled 1 time unit after the rising edge, and inputs are
  // changed at the same moment.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rdy = 1'b1;  pc_flag = 1'b0;  pc_cache = 32'h0;  jp_wrong = 1'b0;
    mc_done = 1'b0;  mc_data = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Columns: name, rdy, pc_flag, pc, jp_wrong, mc_done, mc_data,
    //          exp flag, exp ins_ori, exp mc_req, exp mc_addr
    add("miss0",      1,1,32'h0000_0000,0,0,32'h0,        0,32'h0,        1,32'h0);
    add("fill0_w1",   1,0,32'h0,        0,0,32'h0,        0,32'h0,        1,32'h0);
    add("fill0_pcf",  1,1,32'h0,        0,0,32'h0,        0,32'h0,        1,32'h0);
    add("fill0_done", 1,0,32'h0,        0,1,32'h0000_0093,1,32'h0000_0093,0,32'h0);
    add("idle0",      1,0,32'h0,        0,0,32'h0,        0,32'h0000_0093,0,32'h0);
    add("hit0_a",     1,1,32'h0000_0000,0,0,32'h0,        1,32'h0000_0093,0,32'h0);
    add("hit0_b",     1,1,32'h0000_0003,0,0,32'h0,        1,32'h0000_0093,0,32'h0);
    add("hit0_c",     1,1,32'h0000_0002,0,0,32'h0,        1,32'h0000_0093,0,32'h0);
    add("idle1",      1,0,32'h0,        0,0,32'h0,        0,32'h0000_0093,0,32'h0);
    add("miss104",    1,1,32'h0000_0104,0,0,32'h0,        0,32'h0000_0093,1,32'h104);
    add("done104",    1,0,32'h0,        0,1,32'h1111_1111,1,32'h1111_1111,0,32'h104);
    add("miss204",    1,1,32'h0000_0204,0,0,32'h0,        0,32'h1111_1111,1,32'h204);
    add("wait204",    1,0,32'h0,        0,0,32'h0,        0,32'h1111_1111,1,32'h204);
    add("done204",    1,0,32'h0,        0,1,32'hDEAD_BEEF,1,32'hDEAD_BEEF,0,32'h204);
    add("remiss104",  1,1,32'h0000_0104,0,0,32'h0,        0,32'hDEAD_BEEF,1,32'h104);
    add("redone104",  1,0,32'h0,        0,1,32'h1111_1111,1,32'h1111_1111,0,32'h104);
    add("miss8",      1,1,32'h0000_0008,0,0,32'h0,        0,32'h1111_1111,1,32'h8);
    add("flush8",     1,0,32'h0,        1,0,32'h0,        0,32'h1111_1111,1,32'h8);
    add("wait8",      1,0,32'h0,        0,0,32'h0,        0,32'h1111_1111,1,32'h8);
    add("done8",      1,0,32'h0,        0,1,32'h2222_2222,0,32'h1111_1111,0,32'h8);
    add("hit8",       1,1,32'h0000_0008,0,0,32'h0,        1,32'h2222_2222,0,32'h8);
    add("hit8_jw",    1,1,32'h0000_0008,1,0,32'h0,        0,32'h2222_2222,0,32'h8);
    add("missC_jw",   1,1,32'h0000_000C,1,0,32'h0,        0,32'h2222_2222,0,32'h8);
    add("miss10",     1,1,32'h0000_0010,0,0,32'h0,        0,32'h2222_2222,1,32'h10);
    add("done10_jw",  1,0,32'h0,        1,1,32'h3333_3333,0,32'h2222_2222,0,32'h10);
    add("hit10",      1,1,32'h0000_0010,0,0,32'h0,        1,32'h3333_3333,0,32'h10);
    add("idle_done",  1,0,32'h0,        0,1,32'h0000_0044,0,32'h3333_3333,0,32'h10);
    add("miss14",     1,1,32'h0000_0014,0,0,32'h0,        0,32'h3333_3333,1,32'h14);
    add("frz1",       0,0,32'h0,        0,1,32'h0000_0055,0,32'h3333_3333,1,32'h14);
    add("frz2",       0,0,32'h0,        0,1,32'h0000_0055,0,32'h3333_3333,1,32'h14);
    add("frz3",       0,0,32'h0,        0,1,32'h0000_0055,0,32'h3333_3333,1,32'h14);
    add("frz4",       0,0,32'h0,        0,1,32'h0000_0055,0,32'h3333_3333,1,32'h14);
    add("done14",     1,0,32'h0,        0,1,32'h6666_6666,1,32'h6666_6666,0,32'h14);
    add("frz_pulse",  0,0,32'h0,        0,0,32'h0,        1,32'h6666_6666,0,32'h14);
    add("idle2",      1,0,32'h0,        0,0,32'h0,        0,32'h6666_6666,0,32'h14);
    add("missTop",    1,1,32'hFFFF_FFFC,0,0,32'h0,        0,32'h6666_6666,1,32'hFFFF_FFFC);
    add("doneTop",    1,0,32'h0,        0,1,32'h7777_7777,1,32'h7777_7777,0,32'hFFFF_FFFC);
    add("hitTop",     1,1,32'hFFFF_FFFF,0,0,32'h0,        1,32'h7777_7777,0,32'hFFFF_FFFC);
    add("hit0_again", 1,1,32'h0000_0000,0,0,32'h0,        1,32'h0000_0093,0,32'hFFFF_FFFC);
    add("idle3",      1,0,32'h0,        0,0,32'h0,        0,32'h0000_0093,0,32'hFFFF_FFFC);

    // Reset state.
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check_outputs("reset", 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_outputs("post_reset", 1'b0, 32'h0, 1'b0, 32'h0);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      rdy      = vecs[i].rdy;
      pc_flag  = vecs[i].pc_flag;
      pc_cache = vecs[i].pc;
      jp_wrong = vecs[i].jp_wrong;
      mc_done  = vecs[i].mc_done;
      mc_data  = vecs[i].mc_data;
      tick();
      check_outputs(vecs[i].name, vecs[i].e_flag, vecs[i].e_ins,
                    vecs[i].e_req, vecs[i].e_addr);
    end
    idle_inputs();

    // Asynchronous reset in the middle of a refill.
    pc_flag  = 1'b1;
    pc_cache = 32'h0000_0018;
    tick();
    pc_flag = 1'b0;
    check_outputs("miss18", 1'b0, 32'h0000_0093, 1'b1, 32'h18);
    #3;
    rst = 1'b1;
    #1;
    check_outputs("async_rst", 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_outputs("after_rst", 1'b0, 32'h0, 1'b0, 32'h0);

    // Every line was invalidated, including the ones filled earlier.
    pc_flag  = 1'b1;
    pc_cache = 32'h0000_0000;
    tick();
    pc_flag = 1'b0;
    check_outputs("rst_miss0", 1'b0, 32'h0, 1'b1, 32'h0);
    mc_done = 1'b1;
    mc_data = 32'h0000_00AA;
    tick();
    mc_done = 1'b0;
    check_outputs("rst_done0", 1'b1, 32'h0000_00AA, 1'b0, 32'h0);
    pc_flag  = 1'b1;
    pc_cache = 32'h0000_0008;
    tick();
    pc_flag = 1'b0;
    check_outputs("rst_miss8", 1'b0, 32'h0000_00AA, 1'b1, 32'h8);
    mc_done = 1'b1;
    mc_data = 32'h0000_00BB;
    tick();
    mc_done = 1'b0;
    check_outputs("rst_done8", 1'b1, 32'h0000_00BB, 1'b0, 32'h8);
    tick();
    check_outputs("final_idle", 1'b0, 32'h0000_00BB, 1'b0, 32'h8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
